div_unit: RTL and testbench

- Multi-cycle iterative divider for the RV64 execute stage. It sits beside the combinational ALU and takes over the divide and remainder opcodes: DIV, DIVU, REM, REMU and their W forms.
- Decode steers these opcodes here, using the same 5-bit sel encoding the ALU uses. The result goes to writeback through a valid/ready handshake.
- Uses radix-2 restoring division on operand magnitudes, with sign fix-up at the end.

---
 rtl/div_unit_pkg.sv | 41 ++++
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared opcode constants, FSM state type and opcode classification helpers
// for the iterative divider; sel codes match the ALU/decode encoding.
package div_unit_pkg;

    localparam logic [4:0] SEL_DIV   = 5'd3;
    localparam logic [4:0] SEL_DIVU  = 5'd4;
    localparam logic [4:0] SEL_REM   = 5'd5;
    localparam logic [4:0] SEL_REMU  = 5'd6;
    localparam logic [4:0] SEL_DIVW  = 5'd25;
    localparam logic [4:0] SEL_DIVUW = 5'd26;
    localparam logic [4:0] SEL_REMW  = 5'd27;
    localparam logic [4:0] SEL_REMUW = 5'd28;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic sel_supported(input logic [4:0] s);
        return s inside {SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU,
                         SEL_DIVW, SEL_DIVUW, SEL_REMW, SEL_REMUW};
    endfunction

    function automatic logic sel_word(input logic [4:0] s);
        return s inside {SEL_DIVW, SEL_DIVUW, SEL_REMW, SEL_REMUW};
    endfunction

    function automatic logic sel_signed(input logic [4:0] s);
        return s inside {SEL_DIV, SEL_REM, SEL_DIVW, SEL_REMW};
    endfunction

    function automatic logic sel_rem(input logic [4:0] s);
        return s inside {SEL_REM, SEL_REMU, SEL_REMW, SEL_REMUW};
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic [N-1:0] quo_next
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Shifted remainder needs N+1 bits: an unsigned divisor may use all N bits.
    always_comb begin
        shifted  = {rem, quo[N-1]};
        diff     = shifted - {1'b0, divisor};
        quo_next = {quo[N-2:0], 1'b0};
        rem_next = shifted[N-1:0];
        if (shifted >= {1'b0, divisor}) begin
            rem_next    = diff[N-1:0];
            quo_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms,
// with valid/ready handshakes on both sides and flush abort.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   sel,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res
);

    localparam int unsigned CW = $clog2(N + 1);

    state_t         state, state_next;
    logic [N-1:0]   rem_q, quo_q, dvs_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q, neg_r, word_q, rem_op_q;

    logic           is_word, is_signed, div_zero, accept, early;
    logic [N-1:0]   a_ext, b_ext, a_mag, b_mag, early_res;
    logic           a_neg, b_neg;
    logic [N-1:0]   rem_next, quo_next, q_fix, r_fix, pick, calc_res;

    div_step #(.N(N)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        is_word   = sel_word(sel);
        is_signed = sel_signed(sel);
        if (is_word) begin
            a_ext = is_signed ? sext32(A[31:0]) : {32'b0, A[31:0]};
            b_ext = is_signed ? sext32(B[31:0]) : {32'b0, B[31:0]};
        end else begin
            a_ext = A;
            b_ext = B;
        end
        a_neg    = is_signed & a_ext[N-1];
        b_neg    = is_signed & b_ext[N-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = is_word ? (B[31:0] == 32'b0) : (B == '0);
        early    = !sel_supported(sel) || div_zero;
        accept   = (state == IDLE) && in_valid && !flush;

        if (!sel_supported(sel))  early_res = '0;
        else if (sel_rem(sel))    early_res = is_word ? sext32(A[31:0]) : A;
        else                      early_res = '1;
    end

    // Fix-up is taken from the final step's outputs so DONE carries the result.
    always_comb begin
        q_fix    = neg_q ? -quo_next : quo_next;
        r_fix    = neg_r ? -rem_next : rem_next;
        pick     = rem_op_q ? r_fix : q_fix;
        calc_res = word_q ? sext32(pick[31:0]) : pick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) state_next = early ? DONE : CALC;
                CALC: if (cnt_q == CW'(1)) state_next = DONE;
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            word_q   <= 1'b0;
            rem_op_q <= 1'b0;
            res      <= '0;
        end else if (accept) begin
            // W dividends sit in the upper half so 32 shifts consume them fully.
            rem_q    <= '0;
            quo_q    <= is_word ? {a_mag[31:0], 32'b0} : a_mag;
            dvs_q    <= b_mag;
            cnt_q    <= is_word ? CW'(32) : CW'(N);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            word_q   <= is_word;
            rem_op_q <= sel_rem(sel);
            if (early) res <= early_res;
        end else if (state == CALC && !flush) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) res <= calc_res;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table through a scoreboard queue,
// plus backpressure, flush and asynchronous reset sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [4:0]  sel;
    logic [63:0] A, B, res;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        string       name;
        logic [4:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.N(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for out_valid; latency is edges after the accept edge.
    task automatic wait_out(input string name, input int lat);
        int edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({name, " latency"}, 64'(edges), 64'(lat));
    endtask

    task automatic issue(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input logic ordy);
        @(negedge clk);
        sel = s; A = a; B = b; in_valid = 1'b1; out_ready = ordy;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A   = {$urandom, $urandom};
        B   = {$urandom, $urandom};
        sel = 5'($urandom);
    endtask

    task automatic pop_check(input string name);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty got %h expected entry", name, res);
        end else begin
            e = exp_q.pop_front();
            chk({name, " res"}, res, e);
        end
    endtask

    initial begin
        vecs.push_back('{"divu",       5'd4,  64'd100, 64'd7, 64'd14, 64});
        vecs.push_back('{"remu",       5'd6,  64'd100, 64'd7, 64'd2,  64});
        vecs.push_back('{"div_neg",    5'd3,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64});
        vecs.push_back('{"rem_neg",    5'd5,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64});
        vecs.push_back('{"div_zero",   5'd3,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0});
        vecs.push_back('{"remw_zero",  5'd27, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 0});
        vecs.push_back('{"divuw_zero", 5'd26, 64'd9, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0});
        vecs.push_back('{"unsupported",5'd7,  64'd5, 64'd3, 64'd0, 0});
        vecs.push_back('{"div_ovf",    5'd3,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64});
        vecs.push_back('{"rem_ovf",    5'd5,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64});
        vecs.push_back('{"divw_ovf",   5'd25, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 32});
        vecs.push_back('{"divuw",      5'd26, 64'h1_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 32});
        vecs.push_back('{"remw_neg",   5'd27, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32});
        vecs.push_back('{"divw_neg",   5'd25, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32});
        vecs.push_back('{"remuw",      5'd28, 64'h1234_5678_0000_0009, 64'hABCD_0000_0000_0004, 64'd1, 32});
        vecs.push_back('{"divu_big",   5'd4,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64});
        vecs.push_back('{"remu_big",   5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64});

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel = '0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset res", res, 64'd0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            wait_out(vecs[i].name, vecs[i].lat);
            pop_check(vecs[i].name);
            @(posedge clk); #1;
            chk({vecs[i].name, " back to idle"}, 64'(in_ready), 64'd1);
        end

        // Backpressure: result held for 10 cycles with out_ready low.
        issue(5'd4, 64'd100, 64'd7, 64'd14, 1'b0);
        wait_out("bp", 64);
        pop_check("bp");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp hold res", res, 64'd14);
            chk("bp hold in_ready", 64'(in_ready), 64'd0);
            chk("bp hold out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        chk("bp release out_valid", 64'(out_valid), 64'd0);

        // Flush at CALC cycle 20 with a competing in_valid that must be ignored.
        @(negedge clk);
        sel = 5'd3; A = 64'd1000; B = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; sel = 5'd4; B = 64'd0;
        @(posedge clk); #1;
        chk("flush in_ready", 64'(in_ready), 64'd1);
        chk("flush out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush no accept", 64'(in_ready), 64'd1);
        begin
            int seen = 0;
            repeat (80) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("flush out_valid never", 64'(seen), 64'd0);
        end
        chk("flush res retained", res, 64'd14);

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        @(negedge clk);
        sel = 5'd4; A = 64'd500; B = 64'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async rst res", res, 64'd0);
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 1'b0;

        issue(5'd4, 64'd500, 64'd9, 64'd55, 1'b1);
        wait_out("post_rst", 64);
        pop_check("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
